stream_vec_packer: RTL and testbench

- Serial-to-parallel front end for the pipelined signed adder tree.
- Accepts a stream of signed samples over a valid/ready handshake and packs INPUT_NUM of them into one flat bus in the adder tree's `din` lane layout.
- Presents each packed vector with valid/ready. An early `in_last` flushes a partial vector with the unused lanes zeroed.
- Sustains one sample per cycle, including across vector boundaries.

---
 rtl/stream_vec_packer.sv | 107 ++++++++++
 tb/tb_stream_vec_packer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_vec_packer.sv
// Serial-to-parallel packer: collects INPUT_NUM signed samples into one flat
// lane vector for the adder tree. An early in_last flushes a partial vector.
module stream_vec_packer #(
   parameter int INPUT_NUM        = 18,
   parameter int INPUT_DATA_WIDTH = 8,
   parameter int CNT_WIDTH        = $clog2(INPUT_NUM + 1)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [INPUT_DATA_WIDTH-1:0]           in_data,
   input  logic                                  in_valid,
   input  logic                                  in_last,
   output logic                                  in_ready,
   output logic [INPUT_NUM*INPUT_DATA_WIDTH-1:0] out_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [CNT_WIDTH-1:0]                  out_count
);

   localparam int IDX_WIDTH = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(INPUT_NUM - 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   typedef logic [INPUT_NUM-1:0][INPUT_DATA_WIDTH-1:0] lanes_t;

   state_e               state_q, state_d;
   logic [IDX_WIDTH-1:0] idx_q, idx_d;
   lanes_t               buf_q, buf_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic accept;
   logic xfer;

   // HOLD drives out_valid straight from the state register, so it never
   // depends combinationally on out_ready.
   assign out_valid = (state_q == HOLD);
   assign in_ready  = rst_n & ((state_q == FILL) | out_ready);
   assign accept    = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;
   assign out_data  = buf_q;
   assign out_count = cnt_q;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         FILL: begin
            if (accept) begin
               buf_d[idx_q] = in_data;
               if (in_last || (idx_q == LAST_IDX)) begin
                  state_d = HOLD;
                  cnt_d   = CNT_WIDTH'(idx_q) + CNT_WIDTH'(1);
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_WIDTH'(1);
               end
            end
         end
         HOLD: begin
            // In HOLD an accept can only happen together with a transfer.
            if (xfer) begin
               buf_d   = '0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = FILL;
               if (accept) begin
                  buf_d[0] = in_data;
                  if (in_last || (INPUT_NUM == 1)) begin
                     state_d = HOLD;
                     cnt_d   = CNT_WIDTH'(1);
                  end else begin
                     idx_d = IDX_WIDTH'(1);
                  end
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   // NOTE: the lane buffer is reset as well, because unwritten lanes must read
   // as zero and a vector pending at reset must never leak out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         idx_q   <= '0;
         buf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_stream_vec_packer.sv
// Directed self-checking bench for stream_vec_packer: inputs are driven and
// outputs sampled on the falling clock edge, expectations computed by hand.
module tb_stream_vec_packer;

   localparam int N  = 18;
   localparam int W  = 8;
   localparam int CW = $clog2(N + 1);
   localparam int DW = N * W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_count;

   int n_checks = 0;
   int n_errors = 0;

   stream_vec_packer #(
      .INPUT_NUM       (N),
      .INPUT_DATA_WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_last  (in_last),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int lane_sum(input logic [DW-1:0] v);
      int s = 0;
      for (int j = 0; j < N; j++) s += int'($signed(v[j*W +: W]));
      return s;
   endfunction

   task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic ordy);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
   endtask

   logic [DW-1:0] exp_vec;
   int            vec_seen;

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);

      // ---------------- reset ----------------
      repeat (3) @(negedge clk);
      drive(1'b1, 8'h11, 1'b0, 1'b1);
      #1;
      check("rst_in_ready", DW'(in_ready), DW'(0));
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_out_count", DW'(out_count), DW'(0));
      check("rst_out_data", out_data, '0);
      drive(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", DW'(in_ready), DW'(1));
      check("post_rst_out_valid", DW'(out_valid), DW'(0));

      // ---------------- full vector 1..18 ----------------
      exp_vec = '0;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         if (i > 0) check("full_no_early_valid", DW'(out_valid), DW'(0));
         drive(1'b1, W'(i + 1), 1'b0, 1'b1);
         exp_vec[i*W +: W] = W'(i + 1);
      end
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("full_valid", DW'(out_valid), DW'(1));
      check("full_count", DW'(out_count), DW'(18));
      check("full_data", out_data, exp_vec);
      check("full_sum", DW'(lane_sum(out_data)), DW'(171));
      @(negedge clk);
      check("full_released", DW'(out_valid), DW'(0));

      // ---------------- early last: -1..-5 ----------------
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(1'b1, W'(-(i + 1)), (i == 4), 1'b1);
      end
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("early_valid", DW'(out_valid), DW'(1));
      check("early_count", DW'(out_count), DW'(5));
      check("early_lane0", DW'(out_data[0 +: W]), DW'(8'hFF));
      check("early_lane4", DW'(out_data[4*W +: W]), DW'(8'hFB));
      check("early_upper_zero", DW'(out_data[DW-1:5*W]), DW'(0));
      check("early_sum", DW'(lane_sum(out_data)), DW'(-15));
      @(negedge clk);
      check("early_released", DW'(out_valid), DW'(0));

      // ---------------- backpressure ----------------
      exp_vec = '0;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         drive(1'b1, W'(i + 20), 1'b0, 1'b0);
         exp_vec[i*W +: W] = W'(i + 20);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         drive(1'b1, W'(8'h60 + c), c[0], 1'b0);
         #1;
         check("bp_in_ready", DW'(in_ready), DW'(0));
         check("bp_valid", DW'(out_valid), DW'(1));
         check("bp_data", out_data, exp_vec);
         check("bp_count", DW'(out_count), DW'(18));
      end
      @(negedge clk);
      drive(1'b1, 8'h55, 1'b0, 1'b1);
      #1;
      check("bp_release_ready", DW'(in_ready), DW'(1));
      check("bp_release_valid", DW'(out_valid), DW'(1));
      @(negedge clk);
      drive(1'b1, 8'h56, 1'b1, 1'b1);
      check("bp_after_valid", DW'(out_valid), DW'(0));
      check("bp_lane0", out_data, DW'(8'h55));
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("bp_tail_count", DW'(out_count), DW'(2));
      check("bp_tail_data", out_data, DW'(16'h5655));
      @(negedge clk);

      // ---------------- back-to-back 1..36 ----------------
      vec_seen = 0;
      for (int i = 0; i <= 2 * N; i++) begin
         @(negedge clk);
         if (out_valid) begin
            exp_vec = '0;
            for (int j = 0; j < N; j++) exp_vec[j*W +: W] = W'(vec_seen * N + j + 1);
            check("b2b_data", out_data, exp_vec);
            check("b2b_count", DW'(out_count), DW'(18));
            check("b2b_slot", DW'(i), DW'((vec_seen + 1) * N));
            vec_seen++;
         end
         if (i < 2 * N) drive(1'b1, W'(i + 1), 1'b0, 1'b1);
         else drive(1'b0, '0, 1'b0, 1'b1);
         #1;
         if (i < 2 * N) check("b2b_no_bubble", DW'(in_ready), DW'(1));
      end
      check("b2b_vectors", DW'(vec_seen), DW'(2));
      @(negedge clk);
      check("b2b_released", DW'(out_valid), DW'(0));

      // ---------------- mid-fill reset ----------------
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive(1'b1, 8'h33, 1'b0, 1'b1);
      end
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", DW'(in_ready), DW'(0));
      check("mid_rst_valid", DW'(out_valid), DW'(0));
      check("mid_rst_data", out_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_vec = '0;
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         check("mid_no_stale_vec", DW'(out_valid), DW'(0));
         drive(1'b1, 8'h10, 1'b0, 1'b1);
         exp_vec[i*W +: W] = 8'h10;
      end
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("mid_valid", DW'(out_valid), DW'(1));
      check("mid_data", out_data, exp_vec);
      check("mid_count", DW'(out_count), DW'(18));
      @(negedge clk);

      // ---------------- boundary collision ----------------
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, W'(i + 1), (i == 2), 1'b0);
      end
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b0);
      check("col_hold_valid", DW'(out_valid), DW'(1));
      check("col_hold_count", DW'(out_count), DW'(3));
      check("col_hold_data", out_data, DW'(24'h030201));
      @(negedge clk);
      drive(1'b1, 8'h7F, 1'b1, 1'b1);
      #1;
      check("col_accept", DW'(in_ready), DW'(1));
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b0);
      check("col_valid", DW'(out_valid), DW'(1));
      check("col_count", DW'(out_count), DW'(1));
      check("col_data", out_data, DW'(8'h7F));
      @(negedge clk);
      check("col_still_held", DW'(out_valid), DW'(1));
      drive(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      check("col_released", DW'(out_valid), DW'(0));
      check("col_cleared", out_data, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
